risc_prog_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the `RISC` core and its instruction memory. Receives a byte-serial program image over a valid/ready stream, assembles 16-bit instruction words, and writes them into instruction memory from address 0. Holds the core in reset until the image is fully written, then releases it so the core's fetch sequence starts at PC 0 with a valid program.

---
 rtl/risc_prog_loader.sv | 178 +++++++++++++++++
 tb/tb_risc_prog_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/risc_prog_loader.sv
// risc_prog_loader: byte-serial boot loader that fills RISC instruction memory.
// Optional trailing checksum byte: define LOADER_CHECKSUM_EN.
module risc_prog_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   input  logic              load_req,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [15:0]       imem_wdata,
   output logic              core_reset,
   output logic              busy,
   output logic              error,
   output logic [ADDR_W:0]   words_loaded
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [2:0] {
      S_HDR_HI,
      S_HDR_LO,
      S_DATA_HI,
      S_DATA_LO,
`ifdef LOADER_CHECKSUM_EN
      S_CHK,
`endif
      S_DONE,
      S_ERROR
   } state_t;

`ifdef LOADER_CHECKSUM_EN
   localparam state_t S_END = S_CHK;
`else
   localparam state_t S_END = S_DONE;
`endif

   state_t            state, state_nxt;
   logic [15:0]       cnt_q, cnt_nxt;
   logic [7:0]        hi_q, hi_nxt;
   logic [ADDR_W:0]   wl_q, wl_nxt;
   logic [ADDR_W:0]   wl_inc;
   logic              we_q, we_nxt;
   logic [ADDR_W-1:0] addr_q, addr_nxt;
   logic [15:0]       wdata_q, wdata_nxt;
   logic              crst_q, crst_nxt;
   logic [15:0]       n_full;
   logic              accept;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        acc_q, acc_nxt;
`endif

   assign busy   = (state != S_DONE) && (state != S_ERROR);
   assign error  = (state == S_ERROR);
   assign rx_ready = busy;
   assign accept = rx_valid && rx_ready;
   assign n_full = {cnt_q[15:8], rx_data};
   assign wl_inc = wl_q + 1'b1;

   assign imem_we      = we_q;
   assign imem_addr    = addr_q;
   assign imem_wdata   = wdata_q;
   assign core_reset   = crst_q;
   assign words_loaded = wl_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_HDR_HI;
         cnt_q   <= '0;
         hi_q    <= '0;
         wl_q    <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         crst_q  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
         acc_q   <= '0;
`endif
      end else begin
         state   <= state_nxt;
         cnt_q   <= cnt_nxt;
         hi_q    <= hi_nxt;
         wl_q    <= wl_nxt;
         we_q    <= we_nxt;
         addr_q  <= addr_nxt;
         wdata_q <= wdata_nxt;
         crst_q  <= crst_nxt;
`ifdef LOADER_CHECKSUM_EN
         acc_q   <= acc_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt_q;
      hi_nxt    = hi_q;
      wl_nxt    = wl_q;
      we_nxt    = 1'b0;
      addr_nxt  = addr_q;
      wdata_nxt = wdata_q;
      crst_nxt  = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      acc_nxt   = acc_q;
      if (accept && state != S_CHK)
         acc_nxt = acc_q ^ rx_data;
`endif
      unique case (state)
         S_HDR_HI: begin
            if (accept) begin
               cnt_nxt[15:8] = rx_data;
               state_nxt     = S_HDR_LO;
            end
         end
         S_HDR_LO: begin
            if (accept) begin
               cnt_nxt = n_full;
               if (n_full == 16'd0)
                  state_nxt = S_END;
               else if ({1'b0, n_full} > 17'(DEPTH))
                  state_nxt = S_ERROR;
               else
                  state_nxt = S_DATA_HI;
            end
         end
         S_DATA_HI: begin
            if (accept) begin
               hi_nxt    = rx_data;
               state_nxt = S_DATA_LO;
            end
         end
         S_DATA_LO: begin
            if (accept) begin
               we_nxt    = 1'b1;
               addr_nxt  = wl_q[ADDR_W-1:0];
               wdata_nxt = {hi_q, rx_data};
               wl_nxt    = wl_inc;
               if (17'(wl_inc) == {1'b0, cnt_q})
                  state_nxt = S_END;
               else
                  state_nxt = S_DATA_HI;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         S_CHK: begin
            if (accept)
               state_nxt = (rx_data == acc_q) ? S_DONE : S_ERROR;
         end
`endif
         S_DONE: begin
            // core leaves reset one edge after DONE, after the last write
            crst_nxt = 1'b0;
            if (load_req) begin
               state_nxt = S_HDR_HI;
               wl_nxt    = '0;
               crst_nxt  = 1'b1;
`ifdef LOADER_CHECKSUM_EN
               acc_nxt   = '0;
`endif
            end
         end
         S_ERROR: begin
            if (load_req) begin
               state_nxt = S_HDR_HI;
               wl_nxt    = '0;
`ifdef LOADER_CHECKSUM_EN
               acc_nxt   = '0;
`endif
            end
         end
         default: state_nxt = S_HDR_HI;
      endcase
   end

endmodule

// File: tb/tb_risc_prog_loader.sv
// tb_risc_prog_loader: scoreboard bench for risc_prog_loader.
// Honours LOADER_CHECKSUM_EN when defined.
module tb_risc_prog_loader;
   localparam int ADDR_W = 8;
   localparam int DEPTH  = 1 << ADDR_W;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [15:0]       data;
   } wr_t;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [7:0]        rx_data = '0;
   logic              rx_valid = 1'b0;
   logic              rx_ready;
   logic              load_req = 1'b0;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [15:0]       imem_wdata;
   logic              core_reset;
   logic              busy;
   logic              error;
   logic [ADDR_W:0]   words_loaded;

   wr_t        exp_q[$];
   logic [7:0] img[$];
   int         vectors = 0;
   int         miscompares = 0;
`ifdef LOADER_CHECKSUM_EN
   bit         bad_chk = 1'b0;
`endif

   risc_prog_loader #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .load_req(load_req),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .core_reset(core_reset), .busy(busy), .error(error),
      .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset && imem_we) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_write: got %0h@%0h expected none",
                     imem_wdata, imem_addr);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (imem_addr !== e.addr || imem_wdata !== e.data) begin
               miscompares++;
               $display("FAIL write: got %0h@%0h expected %0h@%0h",
                        imem_wdata, imem_addr, e.data, e.addr);
            end
         end
      end
   end

   task automatic check_reset_vals();
      check("rst_rx_ready", 32'(rx_ready), 32'd1);
      check("rst_we", 32'(imem_we), 32'd0);
      check("rst_addr", 32'(imem_addr), 32'd0);
      check("rst_wdata", 32'(imem_wdata), 32'd0);
      check("rst_core_reset", 32'(core_reset), 32'd1);
      check("rst_busy", 32'(busy), 32'd1);
      check("rst_error", 32'(error), 32'd0);
      check("rst_words", 32'(words_loaded), 32'd0);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit toggle);
      if (toggle) begin
         rx_valid = 1'b0;
         rx_data  = 8'($urandom);
         load_req = 1'($urandom);
         @(posedge clk); #1;
         load_req = 1'b0;
      end
      check("rx_ready_in_load", 32'(rx_ready), 32'd1);
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic pulse_load();
      load_req = 1'b1;
      @(posedge clk); #1;
      load_req = 1'b0;
      check("reload_busy", 32'(busy), 32'd1);
      check("reload_error", 32'(error), 32'd0);
      check("reload_core_reset", 32'(core_reset), 32'd1);
      check("reload_words", 32'(words_loaded), 32'd0);
   endtask

   task automatic set_img(input logic [127:0] v, input int nb);
      img.delete();
      for (int i = 0; i < nb; i++)
         img.push_back(v[8*(nb-1-i) +: 8]);
   endtask

   task automatic rand_img(input int n);
      img.delete();
      img.push_back(n[15:8]);
      img.push_back(n[7:0]);
      if (n <= DEPTH)
         for (int i = 0; i < 2 * n; i++)
            img.push_back(8'($urandom));
   endtask

   // Reference: word i of the image lands at address i; N > depth is an error.
   task automatic run_image(input bit toggle);
      int n;
      int exp_wl;
      bit exp_err;
      wr_t e;
      if (!busy) pulse_load();
      n = int'({img[0], img[1]});
      if (n > DEPTH) begin
         exp_err = 1'b1;
         exp_wl  = 0;
      end else begin
         exp_err = 1'b0;
         exp_wl  = n;
         for (int i = 0; i < n; i++) begin
            e.addr = ADDR_W'(i);
            e.data = {img[2 + 2 * i], img[3 + 2 * i]};
            exp_q.push_back(e);
         end
      end
      foreach (img[i]) send_byte(img[i], toggle);
`ifdef LOADER_CHECKSUM_EN
      if (!exp_err) begin
         logic [7:0] chk;
         chk = 8'h00;
         foreach (img[i]) chk = chk ^ img[i];
         send_byte(chk ^ {7'd0, bad_chk}, toggle);
         exp_err = bad_chk;
      end
`endif
      check("end_error", 32'(error), 32'(exp_err));
      check("end_busy", 32'(busy), 32'd0);
      check("end_rx_ready", 32'(rx_ready), 32'd0);
      check("end_core_reset_hold", 32'(core_reset), 32'd1);
      check("end_words", 32'(words_loaded), 32'(exp_wl));
      @(posedge clk); #1;
      check("core_reset_after", 32'(core_reset), exp_err ? 32'd1 : 32'd0);
      @(posedge clk); #1;
      check("pending_writes", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      #12;
      check_reset_vals();
      @(posedge clk); #1;
      reset = 1'b1;

      set_img(128'h0003410542030312, 8);
      run_image(1'b0);
      run_image(1'b1);

      set_img(128'h0000, 2);
      run_image(1'b0);

      set_img(128'h0101, 2);
      run_image(1'b0);

      rand_img(DEPTH);
      run_image(1'b0);

`ifdef LOADER_CHECKSUM_EN
      set_img(128'h0003410542030312, 8);
      bad_chk = 1'b1;
      run_image(1'b0);
      bad_chk = 1'b0;
      run_image(1'b0);
`endif

      for (int k = 0; k < 14; k++) begin
         if ($urandom_range(0, 5) == 0)
            rand_img(int'($urandom_range(DEPTH + 1, 65535)));
         else
            rand_img(int'($urandom_range(0, 20)));
         run_image(1'($urandom));
      end

      if (!busy) pulse_load();
      send_byte(8'h00, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h41, 1'b0);
      #2 reset = 1'b0;
      #1;
      check_reset_vals();
      @(posedge clk); #1;
      reset = 1'b1;
      set_img(128'h00011234, 4);
      run_image(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
